// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions for the ALU issue front end.
//   XLEN           data / register width
//   OPC_*          instr[6:2] major opcodes handled by the issue stage
//   imm_fmt_e      which immediate format feeds operand2
//   op1_sel_e      operand1 source
//   op2_sel_e      operand2 source
//   dec_t          per-opcode decode bundle, produced by decode()
package rv32_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_OP     = 5'b01100;

   typedef enum logic [1:0] {
      IMM_NONE = 2'd0,
      IMM_I    = 2'd1,
      IMM_S    = 2'd2,
      IMM_U    = 2'd3
   } imm_fmt_e;

   typedef enum logic [1:0] {
      OP1_ZERO = 2'd0,
      OP1_PC   = 2'd1,
      OP1_RS1  = 2'd2
   } op1_sel_e;

   typedef enum logic [1:0] {
      OP2_ZERO = 2'd0,
      OP2_RS2  = 2'd1,
      OP2_IMM  = 2'd2
   } op2_sel_e;

   typedef struct packed {
      logic     legal;
      op1_sel_e op1_sel;
      op2_sel_e op2_sel;
      imm_fmt_e imm_fmt;
      logic     use_rs1;
      logic     use_rs2;
      logic     writes_rd;
      logic     func7_en;
   } dec_t;

   // Opcode-only decode; the instr[1:0]==11 check is applied by the caller.
   function automatic dec_t decode(input logic [4:0] opc, input logic [2:0] f3);
      dec_t d;
      d.legal     = 1'b0;
      d.op1_sel   = OP1_ZERO;
      d.op2_sel   = OP2_ZERO;
      d.imm_fmt   = IMM_NONE;
      d.use_rs1   = 1'b0;
      d.use_rs2   = 1'b0;
      d.writes_rd = 1'b0;
      d.func7_en  = 1'b0;
      case (opc)
         OPC_LUI: begin
            d.legal     = 1'b1;
            d.op2_sel   = OP2_IMM;
            d.imm_fmt   = IMM_U;
            d.writes_rd = 1'b1;
         end
         OPC_AUIPC: begin
            d.legal     = 1'b1;
            d.op1_sel   = OP1_PC;
            d.op2_sel   = OP2_IMM;
            d.imm_fmt   = IMM_U;
            d.writes_rd = 1'b1;
         end
         OPC_JAL: begin
            d.legal     = 1'b1;
            d.op1_sel   = OP1_PC;
            d.writes_rd = 1'b1;
         end
         OPC_JALR: begin
            // rs1 only feeds the target adder outside this block, but it
            // still has to be hazard-checked.
            d.legal     = 1'b1;
            d.op1_sel   = OP1_PC;
            d.use_rs1   = 1'b1;
            d.writes_rd = 1'b1;
         end
         OPC_BRANCH: begin
            d.legal   = 1'b1;
            d.op1_sel = OP1_RS1;
            d.op2_sel = OP2_RS2;
            d.use_rs1 = 1'b1;
            d.use_rs2 = 1'b1;
         end
         OPC_LOAD: begin
            d.legal     = 1'b1;
            d.op1_sel   = OP1_RS1;
            d.op2_sel   = OP2_IMM;
            d.imm_fmt   = IMM_I;
            d.use_rs1   = 1'b1;
            d.writes_rd = 1'b1;
         end
         OPC_STORE: begin
            d.legal   = 1'b1;
            d.op1_sel = OP1_RS1;
            d.op2_sel = OP2_IMM;
            d.imm_fmt = IMM_S;
            d.use_rs1 = 1'b1;
            d.use_rs2 = 1'b1;
         end
         OPC_OPIMM: begin
            // instr[30] only distinguishes srai from srli among the immediates
            d.legal     = 1'b1;
            d.op1_sel   = OP1_RS1;
            d.op2_sel   = OP2_IMM;
            d.imm_fmt   = IMM_I;
            d.use_rs1   = 1'b1;
            d.writes_rd = 1'b1;
            d.func7_en  = (f3 == 3'b101);
         end
         OPC_OP: begin
            d.legal     = 1'b1;
            d.op1_sel   = OP1_RS1;
            d.op2_sel   = OP2_RS2;
            d.use_rs1   = 1'b1;
            d.use_rs2   = 1'b1;
            d.writes_rd = 1'b1;
            d.func7_en  = 1'b1;
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Sign-extended RV32I immediate extraction (purely combinational).
//   instr  in   instruction bits [31:7] (opcode field not needed)
//   imm_i  out  I-type immediate
//   imm_s  out  S-type immediate
//   imm_u  out  U-type immediate (low 12 bits zero)
module rv32_imm_gen
   import rv32_pkg::*;
(
   input  logic [31:7]     instr,
   output logic [XLEN-1:0] imm_i,
   output logic [XLEN-1:0] imm_s,
   output logic [XLEN-1:0] imm_u
);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_u = {instr[31:12], 12'b0};

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an RV32I instruction, reads the internal register
// file, and presents a registered request to the ALU. A per-register pending
// scoreboard stalls the input while a source (or, optionally, the destination)
// still has a result outstanding.
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           instruction handshake
//   in_instr, in_pc             instruction word and its PC
//   out_valid/out_ready         ALU request handshake
//   out_opcode..out_wb_en       registered request fields
//   illegal                     one-cycle pulse after an illegal instr is dropped
//   wb_valid, wb_rd, wb_data    result writeback into the register file
module alu_issue_stage
   import rv32_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter bit STALL_ON_WAW = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_opcode,
   output logic [2:0]      out_func3,
   output logic            out_func7,
   output logic [XLEN-1:0] out_operand1,
   output logic [XLEN-1:0] out_operand2,
   output logic [4:0]      out_rd,
   output logic            out_wb_en,
   output logic            illegal,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data
);

   logic [XLEN-1:0] rf [1:31];
   logic [31:0]     pend;

   logic [4:0]      opc;
   logic [2:0]      f3;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   dec_t            dec;
   logic            legal;
   logic            wb_en_d;
   logic [4:0]      rd_d;
   logic            func7_d;

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] op1_d;
   logic [XLEN-1:0] op2_d;

   logic [31:0]     wb_clr;
   logic [31:0]     pend_eff;
   logic [31:0]     pend_set;
   logic [31:0]     pend_nxt;
   logic            hazard;
   logic            can_load;
   logic            accept;

   assign opc = in_instr[6:2];
   assign f3  = in_instr[14:12];
   assign rs1 = in_instr[19:15];
   assign rs2 = in_instr[24:20];
   assign rd  = in_instr[11:7];

   rv32_imm_gen u_imm_gen (
      .instr (in_instr[31:7]),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_u (imm_u)
   );

   always_comb begin
      dec     = decode(opc, f3);
      legal   = dec.legal && (in_instr[1:0] == 2'b11);
      wb_en_d = legal && dec.writes_rd && (rd != 5'd0);
      rd_d    = dec.writes_rd ? rd : 5'd0;
      func7_d = dec.func7_en & in_instr[30];
   end

   // Register read with same-cycle writeback bypass; x0 is hardwired zero.
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1 != 5'd0)
         rs1_val = (wb_valid && (wb_rd == rs1)) ? wb_data : rf[rs1];
      if (rs2 != 5'd0)
         rs2_val = (wb_valid && (wb_rd == rs2)) ? wb_data : rf[rs2];
   end

   always_comb begin
      imm = '0;
      case (dec.imm_fmt)
         IMM_I:   imm = imm_i;
         IMM_S:   imm = imm_s;
         IMM_U:   imm = imm_u;
         default: imm = '0;
      endcase

      op1_d = '0;
      case (dec.op1_sel)
         OP1_PC:  op1_d = in_pc;
         OP1_RS1: op1_d = rs1_val;
         default: op1_d = '0;
      endcase

      op2_d = '0;
      case (dec.op2_sel)
         OP2_RS2: op2_d = rs2_val;
         OP2_IMM: op2_d = imm;
         default: op2_d = '0;
      endcase
   end

   // A writeback landing this cycle already releases its register, so the
   // dependent instruction can issue with the bypassed value.
   always_comb begin
      wb_clr   = wb_valid ? (32'd1 << wb_rd) : 32'd0;
      pend_eff = pend & ~wb_clr;
      hazard   = legal && ((dec.use_rs1 && pend_eff[rs1]) ||
                           (dec.use_rs2 && pend_eff[rs2]) ||
                           (STALL_ON_WAW && wb_en_d && pend_eff[rd]));
   end

   assign can_load = !out_valid || out_ready;
   assign in_ready = can_load && !hazard;
   assign accept   = in_valid && in_ready;

   // Set is applied after clear so a same-register set/clear keeps the bit.
   always_comb begin
      pend_set    = (accept && wb_en_d) ? (32'd1 << rd) : 32'd0;
      pend_nxt    = pend_eff | pend_set;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_opcode   <= '0;
         out_func3    <= '0;
         out_func7    <= 1'b0;
         out_operand1 <= '0;
         out_operand2 <= '0;
         out_rd       <= '0;
         out_wb_en    <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         illegal <= accept && !legal;
         if (accept && legal) begin
            out_valid    <= 1'b1;
            out_opcode   <= opc;
            out_func3    <= f3;
            out_func7    <= func7_d;
            out_operand1 <= op1_d;
            out_operand2 <= op2_d;
            out_rd       <= rd_d;
            out_wb_en    <= wb_en_d;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++)
            rf[i] <= '0;
      end else if (wb_valid && (wb_rd != 5'd0)) begin
         rf[wb_rd] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pend <= '0;
      else
         pend <= pend_nxt;
   end

endmodule
